// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: consumes one issue-queue request at a time and
// sequences write-buffer, linefill-buffer, SRAM, channel and BIU traffic.
module bank_sram_ctrl #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iq_sc_valid_i,
    output logic                  iq_sc_ready_o,
    input  logic [1:0]            iq_sc_channel_id_i,
    input  logic [2:0]            iq_sc_opcode_i,
    input  logic [6:0]            iq_sc_set_way_offset_i,
    input  logic [7:0]            iq_sc_wbuffer_id_i,
    input  logic [2:0]            iq_sc_xbar_rob_num_i,
    input  logic [1:0]            iq_sc_cacheline_state_offset0_i,
    input  logic [1:0]            iq_sc_cacheline_state_offset1_i,
    output logic                  sc_wbuf_ren_o,
    output logic [7:0]            sc_wbuf_rid_o,
    input  logic [DATA_WIDTH-1:0] wbuf_sc_rdata_i,
    output logic                  sc_lfb_ren_o,
    output logic [6:0]            sc_lfb_rid_o,
    input  logic [DATA_WIDTH-1:0] lfb_sc_rdata_i,
    output logic                  sc_sram_cs_o,
    output logic                  sc_sram_we_o,
    output logic [6:0]            sc_sram_addr_o,
    output logic [DATA_WIDTH-1:0] sc_sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_sc_rdata_i,
    output logic                  sc_ch_valid_o,
    output logic [1:0]            sc_ch_id_o,
    output logic [2:0]            sc_ch_rob_num_o,
    output logic [DATA_WIDTH-1:0] sc_ch_data_o,
    output logic                  sc_biu_wvalid_o,
    input  logic                  biu_sc_wready_i,
    output logic [6:0]            sc_biu_wid_o,
    output logic [DATA_WIDTH-1:0] sc_biu_wdata_o
);

    // DROP is a one-cycle sink for illegal opcodes so they occupy T1 without side effects.
    typedef enum logic [3:0] {
        IDLE, WR_RD, WR_WR, RD_RD, RD_RSP, LF0, LF1, LF2, WB0, WB1, WB2, WB_SEND, DROP
    } state_t;

    state_t                state_q, state_d;
    logic                  beat_sel_q, beat_sel_d;
    logic [1:0]            ch_id_q, ch_id_d;
    logic [6:0]            swo_q, swo_d;
    logic [7:0]            wbuf_id_q, wbuf_id_d;
    logic [2:0]            rob_q, rob_d;
    logic [1:0]            st0_q, st0_d;
    logic [1:0]            st1_q, st1_d;
    logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
    logic [DATA_WIDTH-1:0] beat1_q, beat1_d;

    logic       accept;
    logic       dirty0, dirty1;
    logic [5:0] set_way;

    assign accept  = iq_sc_valid_i && (state_q == IDLE);
    assign dirty0  = (st0_q == 2'b11);
    assign dirty1  = (st1_q == 2'b11);
    assign set_way = swo_q[6:1];

    // Control state: reset aborts any request in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_sel_q <= beat_sel_d;
        end
    end

    // Request fields and write-back beat buffers; only observed while their state is active.
    always_ff @(posedge clk_i) begin
        ch_id_q   <= ch_id_d;
        swo_q     <= swo_d;
        wbuf_id_q <= wbuf_id_d;
        rob_q     <= rob_d;
        st0_q     <= st0_d;
        st1_q     <= st1_d;
        beat0_q   <= beat0_d;
        beat1_q   <= beat1_d;
    end

    // Latch request on accept; capture SRAM read data during write-back reads.
    always_comb begin
        ch_id_d   = ch_id_q;
        swo_d     = swo_q;
        wbuf_id_d = wbuf_id_q;
        rob_d     = rob_q;
        st0_d     = st0_q;
        st1_d     = st1_q;
        beat0_d   = beat0_q;
        beat1_d   = beat1_q;
        if (accept) begin
            ch_id_d   = iq_sc_channel_id_i;
            swo_d     = iq_sc_set_way_offset_i;
            wbuf_id_d = iq_sc_wbuffer_id_i;
            rob_d     = iq_sc_xbar_rob_num_i;
            st0_d     = iq_sc_cacheline_state_offset0_i;
            st1_d     = iq_sc_cacheline_state_offset1_i;
        end
        if (state_q == WB1) beat0_d = sram_sc_rdata_i;
        if (state_q == WB2) beat1_d = sram_sc_rdata_i;
    end

    // Next-state and all outputs, decoded from state and latched fields.
    always_comb begin
        state_d         = state_q;
        beat_sel_d      = beat_sel_q;
        iq_sc_ready_o   = 1'b0;
        sc_wbuf_ren_o   = 1'b0;
        sc_wbuf_rid_o   = '0;
        sc_lfb_ren_o    = 1'b0;
        sc_lfb_rid_o    = '0;
        sc_sram_cs_o    = 1'b0;
        sc_sram_we_o    = 1'b0;
        sc_sram_addr_o  = '0;
        sc_sram_wdata_o = '0;
        sc_ch_valid_o   = 1'b0;
        sc_ch_id_o      = '0;
        sc_ch_rob_num_o = '0;
        sc_ch_data_o    = '0;
        sc_biu_wvalid_o = 1'b0;
        sc_biu_wid_o    = '0;
        sc_biu_wdata_o  = '0;
        case (state_q)
            IDLE: begin
                iq_sc_ready_o = 1'b1;
                if (iq_sc_valid_i) begin
                    case (iq_sc_opcode_i)
                        3'd0:    state_d = WR_RD;
                        3'd1:    state_d = RD_RD;
                        3'd2:    state_d = LF0;
                        3'd3:    state_d = WB0;
                        default: state_d = DROP;
                    endcase
                end
            end
            WR_RD: begin
                sc_wbuf_ren_o = 1'b1;
                sc_wbuf_rid_o = wbuf_id_q;
                state_d       = WR_WR;
            end
            WR_WR: begin
                sc_sram_cs_o    = 1'b1;
                sc_sram_we_o    = 1'b1;
                sc_sram_addr_o  = swo_q;
                sc_sram_wdata_o = wbuf_sc_rdata_i;
                state_d         = IDLE;
            end
            RD_RD: begin
                sc_sram_cs_o   = 1'b1;
                sc_sram_addr_o = swo_q;
                state_d        = RD_RSP;
            end
            RD_RSP: begin
                sc_ch_valid_o   = 1'b1;
                sc_ch_id_o      = ch_id_q;
                sc_ch_rob_num_o = rob_q;
                sc_ch_data_o    = sram_sc_rdata_i;
                state_d         = IDLE;
            end
            LF0: begin
                sc_lfb_ren_o = 1'b1;
                sc_lfb_rid_o = {set_way, 1'b0};
                state_d      = LF1;
            end
            LF1: begin
                sc_sram_cs_o    = 1'b1;
                sc_sram_we_o    = 1'b1;
                sc_sram_addr_o  = {set_way, 1'b0};
                sc_sram_wdata_o = lfb_sc_rdata_i;
                sc_lfb_ren_o    = 1'b1;
                sc_lfb_rid_o    = {set_way, 1'b1};
                if (!swo_q[0]) begin
                    sc_ch_valid_o   = 1'b1;
                    sc_ch_id_o      = ch_id_q;
                    sc_ch_rob_num_o = rob_q;
                    sc_ch_data_o    = lfb_sc_rdata_i;
                end
                state_d = LF2;
            end
            LF2: begin
                sc_sram_cs_o    = 1'b1;
                sc_sram_we_o    = 1'b1;
                sc_sram_addr_o  = {set_way, 1'b1};
                sc_sram_wdata_o = lfb_sc_rdata_i;
                if (swo_q[0]) begin
                    sc_ch_valid_o   = 1'b1;
                    sc_ch_id_o      = ch_id_q;
                    sc_ch_rob_num_o = rob_q;
                    sc_ch_data_o    = lfb_sc_rdata_i;
                end
                state_d = IDLE;
            end
            WB0: begin
                sc_sram_cs_o   = 1'b1;
                sc_sram_addr_o = {set_way, 1'b0};
                state_d        = WB1;
            end
            WB1: begin
                sc_sram_cs_o   = 1'b1;
                sc_sram_addr_o = {set_way, 1'b1};
                state_d        = WB2;
            end
            WB2: begin
                if (dirty0) begin
                    beat_sel_d = 1'b0;
                    state_d    = WB_SEND;
                end else if (dirty1) begin
                    beat_sel_d = 1'b1;
                    state_d    = WB_SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            WB_SEND: begin
                sc_biu_wvalid_o = 1'b1;
                sc_biu_wid_o    = {set_way, beat_sel_q};
                sc_biu_wdata_o  = beat_sel_q ? beat1_q : beat0_q;
                if (biu_sc_wready_i) begin
                    if (!beat_sel_q && dirty1) beat_sel_d = 1'b1;
                    else                       state_d    = IDLE;
                end
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Directed bench for bank_sram_ctrl: one linear sequence of requests with
// hand-computed expectations checked by immediate assertions.
module tb_bank_sram_ctrl;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          iq_valid;
    logic          iq_ready;
    logic [1:0]    iq_ch;
    logic [2:0]    iq_op;
    logic [6:0]    iq_swo;
    logic [7:0]    iq_wbid;
    logic [2:0]    iq_rob;
    logic [1:0]    iq_st0;
    logic [1:0]    iq_st1;
    logic          wbuf_ren;
    logic [7:0]    wbuf_rid;
    logic [DW-1:0] wbuf_rdata;
    logic          lfb_ren;
    logic [6:0]    lfb_rid;
    logic [DW-1:0] lfb_rdata;
    logic          sram_cs;
    logic          sram_we;
    logic [6:0]    sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          ch_valid;
    logic [1:0]    ch_id;
    logic [2:0]    ch_rob;
    logic [DW-1:0] ch_data;
    logic          biu_wvalid;
    logic          biu_wready;
    logic [6:0]    biu_wid;
    logic [DW-1:0] biu_wdata;

    int n_asserts = 0;
    int n_fail    = 0;

    localparam logic [DW-1:0] D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [DW-1:0] D1 = 128'hD1D1_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    localparam logic [DW-1:0] D2 = 128'hD2D2_0123_4567_89AB_CDEF_0000_1234_5678;
    localparam logic [DW-1:0] L0 = 128'h1F00_1111_0000_2222_0000_3333_0000_4444;
    localparam logic [DW-1:0] L1 = 128'h1F11_5555_0000_6666_0000_7777_0000_8888;
    localparam logic [DW-1:0] B0 = 128'hB0B0_B0B0_0000_0000_1234_5678_9ABC_DEF0;
    localparam logic [DW-1:0] B1 = 128'hB1B1_B1B1_FFFF_FFFF_0FED_CBA9_8765_4321;
    localparam logic [DW-1:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    always #5 clk = ~clk;

    bank_sram_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk_i                           (clk),
        .rst_i                           (rst),
        .iq_sc_valid_i                   (iq_valid),
        .iq_sc_ready_o                   (iq_ready),
        .iq_sc_channel_id_i              (iq_ch),
        .iq_sc_opcode_i                  (iq_op),
        .iq_sc_set_way_offset_i          (iq_swo),
        .iq_sc_wbuffer_id_i              (iq_wbid),
        .iq_sc_xbar_rob_num_i            (iq_rob),
        .iq_sc_cacheline_state_offset0_i (iq_st0),
        .iq_sc_cacheline_state_offset1_i (iq_st1),
        .sc_wbuf_ren_o                   (wbuf_ren),
        .sc_wbuf_rid_o                   (wbuf_rid),
        .wbuf_sc_rdata_i                 (wbuf_rdata),
        .sc_lfb_ren_o                    (lfb_ren),
        .sc_lfb_rid_o                    (lfb_rid),
        .lfb_sc_rdata_i                  (lfb_rdata),
        .sc_sram_cs_o                    (sram_cs),
        .sc_sram_we_o                    (sram_we),
        .sc_sram_addr_o                  (sram_addr),
        .sc_sram_wdata_o                 (sram_wdata),
        .sram_sc_rdata_i                 (sram_rdata),
        .sc_ch_valid_o                   (ch_valid),
        .sc_ch_id_o                      (ch_id),
        .sc_ch_rob_num_o                 (ch_rob),
        .sc_ch_data_o                    (ch_data),
        .sc_biu_wvalid_o                 (biu_wvalid),
        .biu_sc_wready_i                 (biu_wready),
        .sc_biu_wid_o                    (biu_wid),
        .sc_biu_wdata_o                  (biu_wdata)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1ns later, well before the rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [6:0] swo,
                         input logic [7:0] wbid, input logic [2:0] rob,
                         input logic [1:0] s0, input logic [1:0] s1);
        iq_valid = 1'b1;
        iq_op    = op;
        iq_ch    = ch;
        iq_swo   = swo;
        iq_wbid  = wbid;
        iq_rob   = rob;
        iq_st0   = s0;
        iq_st1   = s1;
    endtask

    initial begin
        rst        = 1'b1;
        iq_valid   = 1'b0;
        iq_op      = '0;
        iq_ch      = '0;
        iq_swo     = '0;
        iq_wbid    = '0;
        iq_rob     = '0;
        iq_st0     = '0;
        iq_st1     = '0;
        wbuf_rdata = '0;
        lfb_rdata  = '0;
        sram_rdata = '0;
        biu_wready = 1'b0;

        // Reset state
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_ready", iq_ready, 1);
        chk("rst_cs", sram_cs, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_wbuf_ren", wbuf_ren, 0);
        chk("rst_lfb_ren", lfb_ren, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_wvalid", biu_wvalid, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_ch_data", ch_data, 0);
        chk("rst_wid", biu_wid, 0);

        // Write: swo 2A, wbuf 15
        cyc(); issue(3'd0, 2'd0, 7'h2A, 8'h15, 3'd0, 2'b00, 2'b00); #1;
        chk("wr_t0_ready", iq_ready, 1);
        cyc(); iq_valid = 1'b0; #1;
        chk("wr_t1_ready", iq_ready, 0);
        chk("wr_t1_ren", wbuf_ren, 1);
        chk("wr_t1_rid", wbuf_rid, 8'h15);
        chk("wr_t1_cs", sram_cs, 0);
        cyc(); wbuf_rdata = D0; #1;
        chk("wr_t2_cs", sram_cs, 1);
        chk("wr_t2_we", sram_we, 1);
        chk("wr_t2_addr", sram_addr, 7'h2A);
        chk("wr_t2_wdata", sram_wdata, D0);
        chk("wr_t2_ren", wbuf_ren, 0);
        chk("wr_t2_ch", ch_valid, 0);
        cyc(); wbuf_rdata = '0; #1;
        chk("wr_t3_ready", iq_ready, 1);
        chk("wr_t3_cs", sram_cs, 0);
        chk("wr_t3_ch", ch_valid, 0);

        // Read: ch 2, rob 5, addr 11
        cyc(); issue(3'd1, 2'd2, 7'h11, 8'h00, 3'd5, 2'b00, 2'b00); #1;
        chk("rd_t0_ready", iq_ready, 1);
        cyc(); iq_valid = 1'b0; #1;
        chk("rd_t1_cs", sram_cs, 1);
        chk("rd_t1_we", sram_we, 0);
        chk("rd_t1_addr", sram_addr, 7'h11);
        chk("rd_t1_ch", ch_valid, 0);
        cyc(); sram_rdata = D1; #1;
        chk("rd_t2_ch", ch_valid, 1);
        chk("rd_t2_id", ch_id, 2);
        chk("rd_t2_rob", ch_rob, 5);
        chk("rd_t2_data", ch_data, D1);
        chk("rd_t2_cs", sram_cs, 0);
        cyc(); sram_rdata = '0; #1;
        chk("rd_t3_ready", iq_ready, 1);
        chk("rd_t3_ch", ch_valid, 0);

        // Linefill: swo 23 (offset 1), ch 1, rob 3
        cyc(); issue(3'd2, 2'd1, 7'h23, 8'h00, 3'd3, 2'b00, 2'b00); #1;
        cyc(); iq_valid = 1'b0; #1;
        chk("lf_t1_ren", lfb_ren, 1);
        chk("lf_t1_rid", lfb_rid, 7'h22);
        chk("lf_t1_cs", sram_cs, 0);
        cyc(); lfb_rdata = L0; #1;
        chk("lf_t2_cs", sram_cs, 1);
        chk("lf_t2_we", sram_we, 1);
        chk("lf_t2_addr", sram_addr, 7'h22);
        chk("lf_t2_wdata", sram_wdata, L0);
        chk("lf_t2_ren", lfb_ren, 1);
        chk("lf_t2_rid", lfb_rid, 7'h23);
        chk("lf_t2_ch", ch_valid, 0);
        cyc(); lfb_rdata = L1; #1;
        chk("lf_t3_we", sram_we, 1);
        chk("lf_t3_addr", sram_addr, 7'h23);
        chk("lf_t3_wdata", sram_wdata, L1);
        chk("lf_t3_ren", lfb_ren, 0);
        chk("lf_t3_ch", ch_valid, 1);
        chk("lf_t3_id", ch_id, 1);
        chk("lf_t3_rob", ch_rob, 3);
        chk("lf_t3_data", ch_data, L1);
        chk("lf_t3_ready", iq_ready, 0);
        cyc(); lfb_rdata = '0; #1;
        chk("lf_t4_ready", iq_ready, 1);
        chk("lf_t4_ch", ch_valid, 0);

        // Write back, both offsets dirty, wready held low for 3 cycles
        cyc(); issue(3'd3, 2'd0, 7'h40, 8'h00, 3'd0, 2'b11, 2'b11); #1;
        cyc(); iq_valid = 1'b0; #1;
        chk("wb_t1_cs", sram_cs, 1);
        chk("wb_t1_we", sram_we, 0);
        chk("wb_t1_addr", sram_addr, 7'h40);
        cyc(); sram_rdata = B0; #1;
        chk("wb_t2_addr", sram_addr, 7'h41);
        cyc(); sram_rdata = B1; #1;
        chk("wb_t3_wvalid", biu_wvalid, 0);
        chk("wb_t3_ready", iq_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); sram_rdata = JUNK; biu_wready = 1'b0; #1;
            chk("wb_hold_wvalid", biu_wvalid, 1);
            chk("wb_hold_wid", biu_wid, 7'h40);
            chk("wb_hold_wdata", biu_wdata, B0);
        end
        cyc(); biu_wready = 1'b1; #1;
        chk("wb_hs0_wvalid", biu_wvalid, 1);
        chk("wb_hs0_wid", biu_wid, 7'h40);
        cyc(); biu_wready = 1'b1; #1;
        chk("wb_hs1_wvalid", biu_wvalid, 1);
        chk("wb_hs1_wid", biu_wid, 7'h41);
        chk("wb_hs1_wdata", biu_wdata, B1);
        chk("wb_hs1_ready", iq_ready, 0);
        cyc(); biu_wready = 1'b0; sram_rdata = '0; #1;
        chk("wb_done_ready", iq_ready, 1);
        chk("wb_done_wvalid", biu_wvalid, 0);

        // Write back with nothing dirty
        cyc(); issue(3'd3, 2'd0, 7'h50, 8'h00, 3'd0, 2'b10, 2'b01); #1;
        cyc(); iq_valid = 1'b0; #1;
        chk("wbc_t1_wvalid", biu_wvalid, 0);
        cyc(); #1;
        chk("wbc_t2_wvalid", biu_wvalid, 0);
        cyc(); #1;
        chk("wbc_t3_wvalid", biu_wvalid, 0);
        chk("wbc_t3_ready", iq_ready, 0);
        cyc(); #1;
        chk("wbc_t4_ready", iq_ready, 1);
        chk("wbc_t4_wvalid", biu_wvalid, 0);

        // Illegal opcode: dropped, ready back at T2
        cyc(); issue(3'd5, 2'd3, 7'h7F, 8'hFF, 3'd7, 2'b11, 2'b11); #1;
        cyc(); iq_valid = 1'b0; #1;
        chk("ill_t1_ready", iq_ready, 0);
        chk("ill_t1_cs", sram_cs, 0);
        chk("ill_t1_ren", wbuf_ren, 0);
        chk("ill_t1_lfb", lfb_ren, 0);
        chk("ill_t1_ch", ch_valid, 0);
        chk("ill_t1_wvalid", biu_wvalid, 0);
        cyc(); #1;
        chk("ill_t2_ready", iq_ready, 1);
        chk("ill_t2_wvalid", biu_wvalid, 0);

        // Reset while a write-back beat is pending
        cyc(); issue(3'd3, 2'd0, 7'h60, 8'h00, 3'd0, 2'b11, 2'b00); #1;
        cyc(); iq_valid = 1'b0; #1;
        cyc(); sram_rdata = B0; #1;
        cyc(); sram_rdata = B1; #1;
        cyc(); biu_wready = 1'b0; #1;
        chk("rstwb_wvalid", biu_wvalid, 1);
        chk("rstwb_wid", biu_wid, 7'h60);
        rst = 1'b1;
        cyc(); rst = 1'b0; sram_rdata = '0; #1;
        chk("rstwb_after_wvalid", biu_wvalid, 0);
        chk("rstwb_after_ready", iq_ready, 1);
        chk("rstwb_after_wid", biu_wid, 0);

        // Read after reset: ch 3, rob 7, addr 05
        issue(3'd1, 2'd3, 7'h05, 8'h00, 3'd7, 2'b00, 2'b00); #1;
        cyc(); iq_valid = 1'b0; #1;
        chk("rd2_t1_cs", sram_cs, 1);
        chk("rd2_t1_addr", sram_addr, 7'h05);
        cyc(); sram_rdata = D2; #1;
        chk("rd2_t2_ch", ch_valid, 1);
        chk("rd2_t2_id", ch_id, 3);
        chk("rd2_t2_rob", ch_rob, 7);
        chk("rd2_t2_data", ch_data, D2);
        cyc(); sram_rdata = '0; #1;
        chk("rd2_t3_ready", iq_ready, 1);
        chk("rd2_t3_ch", ch_valid, 0);
        chk("rd2_t3_wvalid", biu_wvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
